// File: rtl/paddle_motion.sv
// Paddle motion: frame-paced left/right movement with stepped acceleration,
// wall clamping, and a registered one-cycle-latency pixel renderer.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   frameTick         one-cycle pulse per frame; motion advances only then
//   moveLeft/Right    level button requests (both high = no request)
//   xIndex, yIndex    current pixel column / row
//   displayEnable     high in the visible region
//   color             PADDLE_COLOR on a hit, else 0 (registered)
//   shouldDisplay     paddle covers the pixel (registered)
//   xPos              paddle left edge
//   speed             current speed, pixels per frame
//   atWall            one-cycle pulse when a move was clamped
module paddle_motion #(
    parameter int         SCREEN_W     = 640,
    parameter int         PADDLE_W     = 100,
    parameter int         Y_TOP        = 440,
    parameter int         Y_BOT        = 460,
    parameter int         MIN_X        = 4,
    parameter int         MAX_X        = 540,
    parameter int         START_X      = 5,
    parameter int         MAX_SPEED    = 7,
    parameter int         ACCEL_FRAMES = 2,
    parameter logic [7:0] PADDLE_COLOR = 8'b01101101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frameTick,
    input  logic       moveLeft,
    input  logic       moveRight,
    input  logic [9:0] xIndex,
    input  logic [9:0] yIndex,
    input  logic       displayEnable,
    output logic [7:0] color,
    output logic       shouldDisplay,
    output logic [9:0] xPos,
    output logic [3:0] speed,
    output logic       atWall
);

    // Keep the paddle fully on screen even if MAX_X was set too far right.
    localparam int RIGHT_LIMIT = (MAX_X + PADDLE_W <= SCREEN_W) ?
                                 MAX_X : SCREEN_W - PADDLE_W;
    localparam int CW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCEL_FRAMES - 1);
    localparam logic [3:0]    SPD_MAX  = 4'(MAX_SPEED);

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        CRUISE
    } state_t;

    state_t        state_q, state_d;
    logic          dir_r_q, dir_r_d;
    logic [3:0]    speed_q, speed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    x_q, x_d;
    logic          wall_q, wall_d;
    logic          disp_q, disp_d;
    logic [7:0]    color_q, color_d;

    logic          req_l;
    logic          req_r;
    logic          req_any;
    logic [10:0]   x_ext;
    logic [10:0]   spd_ext;
    logic [10:0]   x_end;
    logic          hit;

    assign req_l   = moveLeft & ~moveRight;
    assign req_r   = moveRight & ~moveLeft;
    assign req_any = req_l | req_r;

    always_comb begin
        state_d = state_q;
        dir_r_d = dir_r_q;
        speed_d = speed_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        wall_d  = 1'b0;
        x_ext   = {1'b0, x_q};
        spd_ext = 11'd0;

        if (frameTick) begin
            if (!req_any) begin
                state_d = IDLE;
                speed_d = 4'd0;
                cnt_d   = '0;
            end else if (state_q == IDLE || req_r != dir_r_q) begin
                // Fresh start or reversal: restart the ramp at speed 1.
                dir_r_d = req_r;
                speed_d = 4'd1;
                cnt_d   = '0;
                state_d = (SPD_MAX == 4'd1) ? CRUISE : RAMP;
            end else begin
                case (state_q)
                    RAMP: begin
                        if (cnt_q == CNT_LAST) begin
                            speed_d = speed_q + 4'd1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        state_d = (speed_d == SPD_MAX) ? CRUISE : RAMP;
                    end
                    CRUISE: begin
                        speed_d = SPD_MAX;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end

            if (req_any) begin
                // 11-bit compares so neither edge can wrap.
                spd_ext = {7'd0, speed_d};
                if (!dir_r_d) begin
                    if (x_ext < 11'(MIN_X) + spd_ext) begin
                        x_d    = 10'(MIN_X);
                        wall_d = 1'b1;
                    end else begin
                        x_d = x_q - 10'(speed_d);
                    end
                end else begin
                    if (x_ext + spd_ext > 11'(RIGHT_LIMIT)) begin
                        x_d    = 10'(RIGHT_LIMIT);
                        wall_d = 1'b1;
                    end else begin
                        x_d = x_q + 10'(speed_d);
                    end
                end
                if (wall_d) begin
                    speed_d = 4'd0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    // Hit test uses the pre-edge paddle position.
    assign x_end = {1'b0, x_q} + 11'(PADDLE_W) - 11'd1;
    assign hit   = displayEnable
                 && ({1'b0, xIndex} >= {1'b0, x_q})
                 && ({1'b0, xIndex} <= x_end)
                 && (yIndex >= 10'(Y_TOP))
                 && (yIndex <= 10'(Y_BOT));

    always_comb begin
        disp_d  = hit;
        color_d = hit ? PADDLE_COLOR : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_r_q <= 1'b1;
            speed_q <= 4'd0;
            cnt_q   <= '0;
            x_q     <= 10'(START_X);
            wall_q  <= 1'b0;
            disp_q  <= 1'b0;
            color_q <= 8'h00;
        end else begin
            state_q <= state_d;
            dir_r_q <= dir_r_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            wall_q  <= wall_d;
            disp_q  <= disp_d;
            color_q <= color_d;
        end
    end

    assign xPos          = x_q;
    assign speed         = speed_q;
    assign atWall        = wall_q;
    assign shouldDisplay = disp_q;
    assign color         = color_q;

endmodule

// File: tb/tb_paddle_motion.sv
// Self-checking bench for paddle_motion: directed scenarios plus randomized
// button/tick/pixel stimulus against a frame-level behavioural model.
module tb_paddle_motion;

    localparam int PW    = 100;
    localparam int YT    = 440;
    localparam int YB    = 460;
    localparam int MINX  = 4;
    localparam int MAXX  = 540;
    localparam int STX   = 5;
    localparam int MSPD  = 7;
    localparam int AF    = 2;
    localparam int PCOL  = 8'h6D;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frameTick = 1'b0;
    logic       moveLeft = 1'b0;
    logic       moveRight = 1'b0;
    logic [9:0] xIndex = '0;
    logic [9:0] yIndex = '0;
    logic       displayEnable = 1'b0;
    logic [7:0] color;
    logic       shouldDisplay;
    logic [9:0] xPos;
    logic [3:0] speed;
    logic       atWall;

    int n_total = 0;
    int n_pass  = 0;

    // Model: position, consecutive same-direction ticks held, direction.
    int m_pos = STX;
    int m_held = 0;
    int m_dir = 1;
    int m_spd = 0;
    int e_wall = 0;
    int e_disp = 0;
    int e_col = 0;

    paddle_motion dut (
        .clk(clk),
        .reset(reset),
        .frameTick(frameTick),
        .moveLeft(moveLeft),
        .moveRight(moveRight),
        .xIndex(xIndex),
        .yIndex(yIndex),
        .displayEnable(displayEnable),
        .color(color),
        .shouldDisplay(shouldDisplay),
        .xPos(xPos),
        .speed(speed),
        .atWall(atWall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d @%0t",
                      name, act, exp, $time);
    endtask

    function automatic int hit_of(input int pos, input int xi,
                                  input int yi, input int de);
        return (de != 0 && xi >= pos && xi < pos + PW &&
                yi >= YT && yi <= YB) ? 1 : 0;
    endfunction

    // Advance the model one clock given this cycle's inputs.
    task automatic model_step(input int rs, input int tk, input int ml,
                              input int mr, input int xi, input int yi,
                              input int de);
        int d;
        int s;
        int np;
        if (rs != 0) begin
            m_pos = STX; m_held = 0; m_dir = 1; m_spd = 0;
            e_wall = 0; e_disp = 0; e_col = 0;
            return;
        end
        e_disp = hit_of(m_pos, xi, yi, de);
        e_col  = e_disp ? PCOL : 0;
        e_wall = 0;
        if (tk == 0) return;
        if ((ml ^ mr) == 0) begin
            m_held = 0; m_spd = 0;
            return;
        end
        d = (mr != 0) ? 1 : -1;
        if (m_held == 0 || d != m_dir) m_held = 1;
        else m_held++;
        m_dir = d;
        s = 1 + (m_held - 1) / AF;
        if (s > MSPD) s = MSPD;
        np = m_pos + d * s;
        if (np < MINX || np > MAXX) begin
            m_pos = (np < MINX) ? MINX : MAXX;
            e_wall = 1; m_held = 0; m_spd = 0;
        end else begin
            m_pos = np; m_spd = s;
        end
    endtask

    // Drive one cycle, update the model, sample #1 after the edge, compare.
    task automatic cyc(input int rs, input int tk, input int ml, input int mr,
                       input int xi, input int yi, input int de);
        reset = rs[0]; frameTick = tk[0];
        moveLeft = ml[0]; moveRight = mr[0];
        xIndex = 10'(xi); yIndex = 10'(yi); displayEnable = de[0];
        model_step(rs, tk, ml, mr, xi & 1023, yi & 1023, de);
        @(posedge clk);
        #1;
        chk("xPos", int'(xPos), m_pos);
        chk("speed", int'(speed), m_spd);
        chk("atWall", int'(atWall), e_wall);
        chk("shouldDisplay", int'(shouldDisplay), e_disp);
        chk("color", int'(color), e_col);
    endtask

    task automatic tick(input int ml, input int mr);
        cyc(0, 1, ml, mr, 0, 0, 0);
    endtask

    task automatic idle_cyc();
        cyc(0, 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            0, 0, 0);
    endtask

    int seq_x [13] = '{6, 7, 9, 11, 14, 17, 21, 25, 30, 35, 41, 47, 54};
    int seq_s [13] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7};
    int px4 [4] = '{4, 5, 104, 105};
    int pd4 [4] = '{0, 1, 1, 0};

    initial begin
        int ml;
        int mr;
        int xi;

        // Reset defaults
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_xPos", int'(xPos), 5);
        chk("rst_speed", int'(speed), 0);
        chk("rst_disp", int'(shouldDisplay), 0);
        chk("rst_wall", int'(atWall), 0);

        // Acceleration ramp, with ignored inputs between ticks
        for (int i = 0; i < 13; i++) begin
            tick(0, 1);
            chk("ramp_x", int'(xPos), seq_x[i]);
            chk("ramp_s", int'(speed), seq_s[i]);
            idle_cyc();
            idle_cyc();
            chk("hold_x", int'(xPos), seq_x[i]);
        end
        chk("model_ramp_end", m_pos, 54);
        tick(0, 1);
        chk("cruise_x", int'(xPos), 61);
        chk("cruise_s", int'(speed), 7);

        // Left wall
        cyc(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0);
        chk("lw1_x", int'(xPos), 4);
        chk("lw1_wall", int'(atWall), 0);
        tick(1, 0);
        chk("lw2_x", int'(xPos), 4);
        chk("lw2_wall", int'(atWall), 1);
        chk("lw2_s", int'(speed), 0);
        idle_cyc();
        chk("lw_pulse_end", int'(atWall), 0);

        // Both buttons then reverse
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1);
        chk("b_pre_s", int'(speed), 3);
        tick(1, 1);
        chk("both_x", int'(xPos), 14);
        chk("both_s", int'(speed), 0);
        tick(1, 0);
        chk("rev_x", int'(xPos), 13);
        chk("rev_s", int'(speed), 1);

        // Render edges
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, px4[i], 450, 1);
            chk("rend_disp", int'(shouldDisplay), pd4[i]);
            chk("rend_col", int'(color), pd4[i] ? 8'h6D : 0);
        end
        cyc(0, 0, 0, 0, 50, 450, 0);
        chk("rend_de0", int'(shouldDisplay), 0);
        chk("rend_de0_col", int'(color), 0);
        cyc(0, 0, 0, 0, 50, 439, 1);
        chk("rend_y439", int'(shouldDisplay), 0);
        cyc(0, 0, 0, 0, 50, 461, 1);
        chk("rend_y461", int'(shouldDisplay), 0);
        cyc(0, 0, 0, 0, 50, 460, 1);
        chk("rend_y460", int'(shouldDisplay), 1);

        // Reset wins over a tick while cruising
        for (int i = 0; i < 48; i++) tick(0, 1);
        chk("pre_rst_x", int'(xPos), 299);
        cyc(1, 1, 0, 1, 0, 0, 0);
        chk("rst_tick_x", int'(xPos), 5);
        chk("rst_tick_s", int'(speed), 0);

        // Randomized run with sticky buttons
        ml = 0; mr = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                ml = int'($urandom_range(0, 1));
                mr = int'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 1) == 0)
                xi = m_pos + int'($urandom_range(0, 106)) - 3;
            else
                xi = int'($urandom_range(0, 1023));
            cyc(($urandom_range(0, 399) == 0) ? 1 : 0,
                ($urandom_range(0, 2) == 0) ? 1 : 0,
                ml, mr, xi, int'($urandom_range(436, 464)),
                ($urandom_range(0, 7) != 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
